// File: rtl/mc_burst_pkg.sv
// mc_burst_pkg: shared definitions for the burst address sequencer.
//   mc_bs_state_e    : two-state sequencer encoding (IDLE / RUN)
//   MC_BS_WRAP_LENS  : burst lengths (in beats) that may wrap
//   mc_bs_mask_width : log2 of a legal wrap length, 0 for any other length
package mc_burst_pkg;

  typedef enum logic {
    MC_BS_IDLE = 1'b0,
    MC_BS_RUN  = 1'b1
  } mc_bs_state_e;

  localparam int unsigned MC_BS_NUM_WRAP_LENS = 4;
  localparam int unsigned MC_BS_WRAP_LENS [MC_BS_NUM_WRAP_LENS] = '{2, 4, 8, 16};

  // Returns the number of low address bits that wrap for a burst of
  // `beats` beats, or 0 when that length cannot wrap (run as linear).
  function automatic int unsigned mc_bs_mask_width(input int unsigned beats);
    mc_bs_mask_width = 0;
    for (int unsigned i = 0; i < MC_BS_NUM_WRAP_LENS; i++) begin
      if (beats == MC_BS_WRAP_LENS[i]) begin
        mc_bs_mask_width = $clog2(MC_BS_WRAP_LENS[i]);
      end
    end
  endfunction

endpackage

// File: rtl/mc_burst_inc.sv
// mc_burst_inc: split-carry pipelined incrementer.
//   inc_out = inc_in + 1 (mod 2^AW), one clock after inc_in is presented.
//   The low half sum and its carry-out are registered; the high half is
//   registered raw and the carry is added combinationally on the output.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc_in     : value to increment (sampled each rising edge)
//   inc_out    : registered inc_in + 1
module mc_burst_inc
  import mc_burst_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] inc_in,
  output logic [AW-1:0] inc_out
);

  localparam int unsigned LOW  = AW / 2;
  localparam int unsigned HIGH = AW - LOW;

  logic [LOW:0]    lo_sum;
  logic [LOW-1:0]  lo_q;
  logic [HIGH-1:0] hi_q;
  logic            carry_q;

  assign lo_sum = {1'b0, inc_in[LOW-1:0]} + (LOW+1)'(1);

  // Reset image matches inc_in == 0, so inc_out == 1 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q    <= LOW'(1);
      carry_q <= 1'b0;
      hi_q    <= '0;
    end else begin
      lo_q    <= lo_sum[LOW-1:0];
      carry_q <= lo_sum[LOW];
      hi_q    <= inc_in[AW-1:LOW];
    end
  end

  assign inc_out = {hi_q + HIGH'(carry_q), lo_q};

endmodule

// File: rtl/mc_burst_seq.sv
// mc_burst_seq: burst address sequencer.
//   Accepts (start_addr, start_len = beats-1, start_wrap) on a valid/ready
//   handshake and issues one beat address per cycle on addr/addr_valid,
//   flagging the final beat with addr_last. abort cancels any burst.
// Ports:
//   clk, rst_n                          : clock, async active-low reset
//   start_valid/start_ready             : command handshake
//   start_addr, start_len, start_wrap   : command fields
//   addr_valid/addr_ready, addr, addr_last : beat address handshake
//   abort                               : synchronous burst cancel
//   busy                                : burst in progress
// Build option: MC_BURST_WRAP_EN enables wrapping bursts; without it
// start_wrap is ignored and every burst is linear.
module mc_burst_seq
  import mc_burst_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned LW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic [AW-1:0] start_addr,
  input  logic [LW-1:0] start_len,
  input  logic          start_wrap,
  output logic          addr_valid,
  input  logic          addr_ready,
  output logic [AW-1:0] addr,
  output logic          addr_last,
  input  logic          abort,
  output logic          busy
);

  mc_bs_state_e  state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] beats_q, beats_d;
  logic [AW-1:0] inc_out;
  logic [AW-1:0] next_addr;
  logic          load;

  // The incrementer is fed the value addr_q is about to take, so one cycle
  // later inc_out already equals addr_q + 1 and issue never waits on it.
  mc_burst_inc #(
    .AW (AW)
  ) u_inc (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_in  (addr_d),
    .inc_out (inc_out)
  );

`ifdef MC_BURST_WRAP_EN
  logic [AW-1:0] mask_q, mask_d;
  int unsigned   wrap_k;

  always_comb begin
    wrap_k = mc_bs_mask_width(32'(start_len) + 32'd1);
    mask_d = '1;
    if (start_wrap && (wrap_k != 0)) begin
      mask_d = (AW'(1) << wrap_k) - AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '1;
    end else if (load) begin
      mask_q <= mask_d;
    end
  end

  // Bits under the mask take the incremented value, the rest hold.
  assign next_addr = (addr_q & ~mask_q) | (inc_out & mask_q);
`else
  logic unused_wrap;
  assign unused_wrap = start_wrap;
  assign next_addr   = inc_out;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beats_d = beats_q;
    load    = 1'b0;
    if (abort) begin
      state_d = MC_BS_IDLE;
    end else begin
      case (state_q)
        MC_BS_IDLE: begin
          if (start_valid) begin
            load    = 1'b1;
            addr_d  = start_addr;
            beats_d = start_len;
            state_d = MC_BS_RUN;
          end
        end
        MC_BS_RUN: begin
          if (addr_ready) begin
            if (beats_q == '0) begin
              state_d = MC_BS_IDLE;
            end else begin
              addr_d  = next_addr;
              beats_d = beats_q - LW'(1);
            end
          end
        end
        default: state_d = MC_BS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MC_BS_IDLE;
      addr_q  <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beats_q <= beats_d;
    end
  end

  assign start_ready = (state_q == MC_BS_IDLE);
  assign busy        = (state_q == MC_BS_RUN);
  assign addr_valid  = (state_q == MC_BS_RUN);
  assign addr_last   = (state_q == MC_BS_RUN) && (beats_q == '0);
  assign addr        = addr_q;

endmodule
